bloom_filter_csr: RTL

Control/status register slave for the bloom filter. It sits downstream of the per-length match engines and upstream of the host. It owns the global enable and the hash-LUT clean handshake. It also keeps one saturating match counter per (string length, symbol lane) pair, and exposes everything over the 16-bit Avalon-MM CSR port.

---
 rtl/bloom_filter_pkg.sv | 20 ++
 rtl/bloom_filter_sat_cnt.sv | 23 ++
 rtl/bloom_filter_csr.sv | 105 ++++++++++
 3 files changed

// File: rtl/bloom_filter_pkg.sv
// Shared constants and types for the bloom filter CSR slice.
package bloom_filter_pkg;

  localparam int MIN_STR_SIZE     = 5;
  localparam int MAX_STR_SIZE     = 14;
  localparam int AST_SINK_SYMBOLS = 8;

  localparam int AMM_CSR_DATA_W = 16;
  localparam int AMM_CSR_ADDR_W = 12;

  // Register word indices
  localparam int EN             = 0;
  localparam int HASH_LUT_CLEAN = 1;
  localparam int MATCH_CNT_BASE = 2;
  localparam int MATCH_CNT_CNT  = (MAX_STR_SIZE - MIN_STR_SIZE + 1) * AST_SINK_SYMBOLS;
  localparam int REGS_CNT       = MATCH_CNT_BASE + MATCH_CNT_CNT;

  typedef logic [AMM_CSR_DATA_W-1:0] csr_data_t;

endpackage

// File: rtl/bloom_filter_sat_cnt.sv
// Single saturating up-counter; a clear beats an increment in the same cycle.
module bloom_filter_sat_cnt
  import bloom_filter_pkg::*;
(
  input  logic      clk_i,
  input  logic      rst_n_i,
  input  logic      inc_i,
  input  logic      clr_i,
  output csr_data_t value_o
);

  // Count up, stick at all-ones, clear has priority.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      value_o <= '0;
    end else if (clr_i) begin
      value_o <= '0;
    end else if (inc_i && (value_o != '1)) begin
      value_o <= value_o + 1'b1;
    end
  end

endmodule

// File: rtl/bloom_filter_csr.sv
// Avalon-MM CSR slave: global enable, hash-LUT clean handshake and
// per-(length, lane) saturating match counters.
module bloom_filter_csr
  import bloom_filter_pkg::*;
(
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  input  logic [AMM_CSR_ADDR_W-1:0] csr_address_i,
  input  logic                      csr_read_i,
  input  logic                      csr_write_i,
  input  csr_data_t                 csr_writedata_i,
  output csr_data_t                 csr_readdata_o,
  output logic                      csr_readdatavalid_o,
  output logic                      csr_waitrequest_o,
  input  logic                      match_valid_i,
  input  logic [MATCH_CNT_CNT-1:0]  match_i,
  output logic                      en_o,
  output logic                      lut_clean_start_o,
  input  logic                      lut_clean_done_i
);

  localparam logic [AMM_CSR_ADDR_W-1:0] ADDR_EN    = AMM_CSR_ADDR_W'(EN);
  localparam logic [AMM_CSR_ADDR_W-1:0] ADDR_CLEAN = AMM_CSR_ADDR_W'(HASH_LUT_CLEAN);

  logic      clean_busy;
  logic      clean_req;
  csr_data_t rd_data;
  csr_data_t cnt_val [MATCH_CNT_CNT];

  // Only bit0 of the write data is meaningful for EN and HASH_LUT_CLEAN.
  logic unused_wdata;
  assign unused_wdata = ^csr_writedata_i[AMM_CSR_DATA_W-1:1];

  assign csr_waitrequest_o = 1'b0;

  assign clean_req = csr_write_i && (csr_address_i == ADDR_CLEAN) &&
                     csr_writedata_i[0] && !clean_busy;

  // Enable register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      en_o <= 1'b0;
    end else if (csr_write_i && (csr_address_i == ADDR_EN)) begin
      en_o <= csr_writedata_i[0];
    end
  end

  // Clean handshake: one-cycle start pulse, busy until the engine reports done.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      clean_busy        <= 1'b0;
      lut_clean_start_o <= 1'b0;
    end else begin
      lut_clean_start_o <= clean_req;
      if (clean_busy) begin
        if (lut_clean_done_i) clean_busy <= 1'b0;
      end else if (clean_req) begin
        clean_busy <= 1'b1;
      end
    end
  end

  // Match counters; a CSR write to a counter's address clears it.
  for (genvar i = 0; i < MATCH_CNT_CNT; i++) begin : g_cnt
    localparam logic [AMM_CSR_ADDR_W-1:0] ADDR_CNT = AMM_CSR_ADDR_W'(MATCH_CNT_BASE + i);
    logic inc;
    logic clr;
    assign inc = match_valid_i && en_o && match_i[i];
    assign clr = csr_write_i && (csr_address_i == ADDR_CNT);

    bloom_filter_sat_cnt u_cnt (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .inc_i   (inc),
      .clr_i   (clr),
      .value_o (cnt_val[i])
    );
  end

  // Read mux over pre-update register contents; unmapped addresses read 0.
  always_comb begin
    rd_data = '0;
    if (csr_address_i == ADDR_EN) begin
      rd_data[0] = en_o;
    end else if (csr_address_i == ADDR_CLEAN) begin
      rd_data[0] = clean_busy;
    end else begin
      for (int i = 0; i < MATCH_CNT_CNT; i++) begin
        if (csr_address_i == AMM_CSR_ADDR_W'(MATCH_CNT_BASE + i)) rd_data = cnt_val[i];
      end
    end
  end

  // Fixed one-cycle read latency; data holds between reads.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      csr_readdata_o      <= '0;
      csr_readdatavalid_o <= 1'b0;
    end else begin
      csr_readdatavalid_o <= csr_read_i;
      if (csr_read_i) csr_readdata_o <= rd_data;
    end
  end

endmodule
